// File: rtl/occupancy_table_mp_pkg.sv
// rtl/occupancy_table_mp_pkg.sv - shared encodings, error bit indices and FSM states
package occupancy_table_mp_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_REL = 1'b1;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UNF  = 1;
  localparam int ERR_BAD  = 2;
  localparam int ERR_DROP = 3;

  localparam int DEF_CAPACITY = 127;
  localparam int DEF_FULL_ID  = 13;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/occ_sat_update.sv
// rtl/occ_sat_update.sv - combinational saturating add/release of one occupancy value
module occ_sat_update
  import occupancy_table_mp_pkg::*;
#(
  parameter int WIDTH_W  = 7,
  parameter int ADD_W    = 5,
  parameter int CAPACITY = DEF_CAPACITY
) (
  input  logic [WIDTH_W-1:0] old_val,
  input  logic               op,
  input  logic [ADD_W-1:0]   amt,
  output logic [WIDTH_W-1:0] new_val,
  output logic               ovf,
  output logic               unf
);

  localparam logic [WIDTH_W:0] CAP_X = (WIDTH_W+1)'(CAPACITY);

  logic [WIDTH_W:0] amt_x;
  logic [WIDTH_W:0] sum;
  logic [WIDTH_W:0] diff;

  assign amt_x = (WIDTH_W+1)'(amt);
  assign sum   = {1'b0, old_val} + amt_x;
  assign diff  = {1'b0, old_val} - amt_x;

  always_comb begin
    new_val = old_val;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (op == OP_ADD) begin
      if (sum > CAP_X) begin
        new_val = CAP_X[WIDTH_W-1:0];
        ovf     = 1'b1;
      end else begin
        new_val = sum[WIDTH_W-1:0];
      end
    end else begin
      // the extra bit of diff is the borrow: release larger than the stored value
      if (diff[WIDTH_W]) begin
        new_val = '0;
        unf     = 1'b1;
      end else begin
        new_val = diff[WIDTH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/occupancy_table_mp.sv
// rtl/occupancy_table_mp.sv - per-ID occupancy table with multi-port fit reads and clear sweep
module occupancy_table_mp
  import occupancy_table_mp_pkg::*;
#(
  parameter int NUM_IDS  = 14,
  parameter int ID_W     = 4,
  parameter int WIDTH_W  = 7,
  parameter int ADD_W    = 5,
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int FULL_ID  = DEF_FULL_ID,
  parameter int NUM_RD   = 3
) (
  input  logic                      enclk,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      wr_op,
  input  logic [ID_W-1:0]           wr_id,
  input  logic [ADD_W-1:0]          wr_amt,
  input  logic [NUM_RD*ID_W-1:0]    rd_id,
  input  logic [ADD_W-1:0]          req_width,
  output logic [NUM_RD*WIDTH_W-1:0] rd_width,
  output logic [NUM_RD-1:0]         rd_fit,
  input  logic                      clr_start,
  output logic                      busy,
  input  logic                      err_clr,
  output logic [3:0]                err
);

  localparam logic [WIDTH_W-1:0] CAP_V  = WIDTH_W'(CAPACITY);
  localparam logic [WIDTH_W:0]   CAP_X  = (WIDTH_W+1)'(CAPACITY);
  localparam logic [ID_W-1:0]    FULL_V = ID_W'(FULL_ID);
  localparam logic [ID_W-1:0]    LAST_V = ID_W'(NUM_IDS-1);

  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return (32'(id) < NUM_IDS) && (id != FULL_V);
  endfunction

  logic [WIDTH_W-1:0] mem [NUM_IDS];
  state_t             state_q, state_d;
  logic [ID_W-1:0]    cnt_q, cnt_d;
  logic               clr_en;
  logic               wr_ok, wr_acc;
  logic [ID_W-1:0]    wr_idx;
  logic [WIDTH_W-1:0] upd_val;
  logic               upd_ovf, upd_unf;
  logic [3:0]         new_err;
  logic [WIDTH_W-1:0] rd_val [NUM_RD];
  logic [NUM_RD-1:0]  fit_d;

  assign busy   = (state_q == ST_CLEAR);
  assign wr_ok  = id_ok(wr_id);
  assign wr_idx = wr_ok ? wr_id : '0;
  assign wr_acc = we && !busy && wr_ok;

  occ_sat_update #(
    .WIDTH_W (WIDTH_W),
    .ADD_W   (ADD_W),
    .CAPACITY(CAPACITY)
  ) u_upd (
    .old_val(mem[wr_idx]),
    .op     (wr_op),
    .amt    (wr_amt),
    .new_val(upd_val),
    .ovf    (upd_ovf),
    .unf    (upd_unf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_V) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge enclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge enclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IDS; i++) mem[i] <= (i == FULL_ID) ? CAP_V : '0;
    end else begin
      if (wr_acc) mem[wr_idx] <= upd_val;
      if (clr_en && cnt_q != FULL_V) mem[cnt_q] <= '0;
    end
  end

  // busy takes precedence: a dropped write is not also classified by its ID
  always_comb begin
    new_err           = '0;
    new_err[ERR_OVF]  = wr_acc && upd_ovf;
    new_err[ERR_UNF]  = wr_acc && upd_unf;
    new_err[ERR_BAD]  = we && !busy && !wr_ok;
    new_err[ERR_DROP] = we && busy;
  end

  always_ff @(posedge enclk) begin
    if (rst) err <= '0;
    else     err <= (err_clr ? 4'b0000 : err) | new_err;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ID_W-1:0]    id_k;
    logic [WIDTH_W-1:0] val_k;
    logic [WIDTH_W:0]   sum_k;

    assign id_k = rd_id[k*ID_W +: ID_W];

    always_comb begin
      if (!id_ok(id_k))                  val_k = CAP_V;
      else if (clr_en && id_k == cnt_q)  val_k = '0;
      else if (wr_acc && id_k == wr_idx) val_k = upd_val;
      else                               val_k = mem[id_k];
    end

    assign sum_k     = {1'b0, val_k} + (WIDTH_W+1)'(req_width);
    assign rd_val[k] = val_k;
    assign fit_d[k]  = (sum_k <= CAP_X);
  end

  always_ff @(posedge enclk) begin
    if (rst) begin
      rd_width <= '0;
      rd_fit   <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) rd_width[k*WIDTH_W +: WIDTH_W] <= rd_val[k];
      rd_fit <= fit_d;
    end
  end

endmodule
